// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// Module : tpu_pkg
// Shared types and helpers for the systolic operand feeder.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    FLUSH  = 3'd2,
    DONE   = 3'd3,
    CLEAR  = 3'd4
  } feeder_state_t;

  // Cycles needed for the last lane of a tile to drain through the MACs.
  function automatic int flush_count(input int lanes, input int mac_latency);
    return lanes - 1 + mac_latency;
  endfunction

  function automatic int flush_cnt_width(input int lanes, input int mac_latency);
    return $clog2(flush_count(lanes, mac_latency) + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/skew_delay_line.sv
// ---------------------------------------------------------------------------
// Module : skew_delay_line
// Fixed-length {valid, data} shift register; DELAY=0 passes straight through.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module skew_delay_line #(
  parameter int DATA_SIZE = 16,
  parameter int DELAY     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data
);

  generate
    if (DELAY == 0) begin : g_wire
      logic unused_ports;
      assign unused_ports = clk ^ reset;
      assign out_valid    = in_valid;
      assign out_data     = in_data;
    end else begin : g_shift
      logic [DELAY-1:0]     valid_sr;
      logic [DATA_SIZE-1:0] data_sr [DELAY];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_sr <= '0;
          for (int k = 0; k < DELAY; k++) begin
            data_sr[k] <= '0;
          end
        end else begin
          valid_sr[0] <= in_valid;
          data_sr[0]  <= in_data;
          for (int k = 1; k < DELAY; k++) begin
            valid_sr[k] <= valid_sr[k-1];
            data_sr[k]  <= data_sr[k-1];
          end
        end
      end

      assign out_valid = valid_sr[DELAY-1];
      assign out_data  = data_sr[DELAY-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// Module : systolic_skew_feeder
// FIFO-buffered, lane-skewed operand feeder with tile flush/done/clear sequencing.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_skew_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_SIZE   = 16,
  parameter int LANES       = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAC_LATENCY = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [LANES*DATA_SIZE-1:0] inData,
  input  logic                       inLast,
  output logic [LANES*DATA_SIZE-1:0] skewData,
  output logic [LANES-1:0]           laneValid,
  output logic                       macEnable,
  output logic                       macClear,
  output logic                       tileDone
);

  localparam int VEC_W       = LANES * DATA_SIZE;
  localparam int ENTRY_W     = VEC_W + 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int FLUSH_COUNT = flush_count(LANES, MAC_LATENCY);
  localparam int CNT_W       = flush_cnt_width(LANES, MAC_LATENCY);

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  feeder_state_t      state;
  logic [CNT_W-1:0]   flush_cnt;
  logic               issue_valid;
  logic [VEC_W-1:0]   issue_data;

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign inReady = !full;
  assign push    = inValid && !full;
  assign pop     = !empty && ((state == IDLE) || (state == STREAM));
  assign head    = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {inLast, inData};
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Lane-0 issue stage: an empty cycle becomes an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid <= 1'b0;
      issue_data  <= '0;
    end else begin
      issue_valid <= pop;
      issue_data  <= pop ? head[VEC_W-1:0] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      flush_cnt <= '0;
      tileDone  <= 1'b0;
      macClear  <= 1'b0;
    end else begin
      tileDone <= 1'b0;
      macClear <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          if (pop) begin
            if (head[ENTRY_W-1]) begin
              state     <= FLUSH;
              flush_cnt <= CNT_W'(FLUSH_COUNT);
            end else begin
              state <= STREAM;
            end
          end
        end
        FLUSH: begin
          // Leave when this decrement reaches zero, giving FLUSH_COUNT cycles.
          flush_cnt <= flush_cnt - CNT_W'(1);
          if (flush_cnt <= CNT_W'(1)) begin
            state    <= DONE;
            tileDone <= 1'b1;
          end
        end
        DONE: begin
          state    <= CLEAR;
          macClear <= 1'b1;
        end
        CLEAR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      skew_delay_line #(
        .DATA_SIZE (DATA_SIZE),
        .DELAY     (i)
      ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue_valid),
        .in_data   (issue_data[i*DATA_SIZE +: DATA_SIZE]),
        .out_valid (laneValid[i]),
        .out_data  (skewData[i*DATA_SIZE +: DATA_SIZE])
      );
    end
  endgenerate

  assign macEnable = |laneValid;

endmodule

`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// Module : tb_systolic_skew_feeder
// Self-checking bench: event-scheduled reference model plus directed pins.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_systolic_skew_feeder;

  localparam int DS     = 16;
  localparam int LANES  = 4;
  localparam int DEPTH  = 8;
  localparam int MACLAT = 3;
  localparam int FC     = LANES - 1 + MACLAT;
  localparam int VW     = DS * LANES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [VW-1:0] in_data = '0;
  logic          inReady;
  logic [VW-1:0] skewData;
  logic [LANES-1:0] laneValid;
  logic          macEnable;
  logic          macClear;
  logic          tileDone;

  systolic_skew_feeder #(
    .DATA_SIZE   (DS),
    .LANES       (LANES),
    .FIFO_DEPTH  (DEPTH),
    .MAC_LATENCY (MACLAT)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .inValid   (in_valid),
    .inReady   (inReady),
    .inData    (in_data),
    .inLast    (in_last),
    .skewData  (skewData),
    .laneValid (laneValid),
    .macEnable (macEnable),
    .macClear  (macClear),
    .tileDone  (tileDone)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of accepted entries, a per-cycle record of what
  // lane 0 issues, and scheduled cycles for the tile-boundary pulses.
  logic [VW:0]   q [$];
  logic [VW-1:0] hist [int];
  int cyc = 0;
  int done_at = -1;
  int clear_at = -1;
  int allow_from = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  initial begin
    logic [VW:0] e;
    bit was_full;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        hist.delete();
        cyc = 0;
        done_at = -1;
        clear_at = -1;
        allow_from = 0;
      end else begin
        was_full = (q.size() >= DEPTH);
        if (q.size() > 0 && cyc >= allow_from) begin
          e = q.pop_front();
          hist[cyc+1] = e[VW-1:0];
          if (e[VW]) begin
            done_at    = cyc + 1 + FC;
            clear_at   = done_at + 1;
            allow_from = clear_at + 1;
          end
        end
        if (in_valid && !was_full) q.push_back({in_last, in_data});
        cyc++;
      end
    end
  end

  task automatic compare_all;
    logic [VW-1:0]    ed;
    logic [LANES-1:0] ev;
    ed = '0;
    ev = '0;
    for (int i = 0; i < LANES; i++) begin
      if (hist.exists(cyc - i)) begin
        ev[i] = 1'b1;
        ed[i*DS +: DS] = hist[cyc - i][i*DS +: DS];
      end
    end
    chk("skewData",  skewData,  ed);
    chk("laneValid", laneValid, ev);
    chk("macEnable", macEnable, |ev);
    chk("tileDone",  tileDone,  rst_n && cyc == done_at);
    chk("macClear",  macClear,  rst_n && cyc == clear_at);
    chk("inReady",   inReady,   q.size() < DEPTH);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_all();
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (n) next_cycle();
  endtask

  task automatic push(input logic [VW-1:0] d, input logic last, output int stalls);
    stalls = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    forever begin
      @(negedge clk);
      if (inReady) break;
      stalls++;
      if (stalls > 50) begin
        chk("push_timeout", 64'd1, 64'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    next_cycle();
  endtask

  task automatic sample_at(input int n);
    int guard = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (cyc >= n || guard > 1000) break;
    end
  endtask

  function automatic logic [VW-1:0] vec4(input logic [DS-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  int st;
  int st_arr [10];
  int sum_st;
  int td_seen;

  initial begin
    // Single-vector tile timing.
    do_reset();
    in_valid = 1'b1; in_data = vec4(1, 2, 3, 4); in_last = 1'b1;
    next_cycle();
    in_valid = 1'b0; in_last = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      sample_at(c);
      chk("t1_laneValid", laneValid, (c >= 2 && c <= 5) ? (64'd1 << (c - 2)) : 64'd0);
      chk("t1_tileDone", tileDone, c == 8);
      chk("t1_macClear", macClear, c == 9);
      if (c >= 2 && c <= 5) chk("t1_lane", skewData[(c-2)*DS +: DS], c - 1);
    end

    // Back-to-back tiles: B waits until after A's clear.
    do_reset();
    push(vec4(1, 1, 1, 1), 1'b0, st);
    push(vec4(2, 2, 2, 2), 1'b0, st);
    push(vec4(3, 3, 3, 3), 1'b1, st);
    push(vec4(16'h0b01, 7, 7, 7), 1'b0, st);
    push(vec4(16'h0b02, 8, 8, 8), 1'b1, st);
    in_valid = 1'b0; in_last = 1'b0;
    sample_at(10); chk("t2_tileDone", tileDone, 1);
    sample_at(11); chk("t2_macClear", macClear, 1); chk("t2_lv0_clear", laneValid[0], 0);
    sample_at(12); chk("t2_lv0_idle", laneValid[0], 0);
    sample_at(13); chk("t2_lv0_b", laneValid[0], 1); chk("t2_b0", skewData[DS-1:0], 16'h0b01);
    sample_at(20); chk("t2_tileDone_b", tileDone, 1);

    // FIFO full: nine accepted, tenth stalls until the IDLE pop frees a slot.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      push(vec4(k + 1, k + 2, k + 3, k + 4), k == 0, st_arr[k]);
    end
    in_valid = 1'b0; in_last = 1'b0;
    sum_st = 0;
    for (int k = 0; k < 9; k++) sum_st += st_arr[k];
    chk("t3_first9_stalls", sum_st, 0);
    chk("t3_tenth_stalls", st_arr[9], 2);
    idle(30);

    // Bubbles inside a tile.
    do_reset();
    fork
      begin
        push(vec4(5, 5, 5, 5), 1'b0, st);
        idle(2);
        push(vec4(-16'sd3, -16'sd3, -16'sd3, -16'sd3), 1'b1, st);
        in_valid = 1'b0; in_last = 1'b0;
      end
      begin
        sample_at(2); chk("t4_l0_c2", skewData[DS-1:0], 16'd5);     chk("t4_v0_c2", laneValid[0], 1);
        sample_at(3); chk("t4_l0_c3", skewData[DS-1:0], 16'd0);     chk("t4_v0_c3", laneValid[0], 0);
        chk("t4_men_c3", macEnable, 1);
        sample_at(4); chk("t4_l0_c4", skewData[DS-1:0], 16'd0);     chk("t4_v0_c4", laneValid[0], 0);
        sample_at(5); chk("t4_l0_c5", skewData[DS-1:0], 16'hfffd);  chk("t4_v0_c5", laneValid[0], 1);
        sample_at(9); chk("t4_men_c9", macEnable, 0);
      end
    join
    idle(20);

    // Signed extremes pass bit-exact.
    do_reset();
    push(vec4(16'h8000, 16'h7fff, 16'h8000, 16'h7fff), 1'b1, st);
    in_valid = 1'b0; in_last = 1'b0;
    sample_at(4); chk("t5_lane2", skewData[2*DS +: DS], 16'h8000);
    sample_at(5); chk("t5_lane3", skewData[3*DS +: DS], 16'h7fff);
    idle(15);

    // Asynchronous reset during FLUSH.
    do_reset();
    in_valid = 1'b1; in_data = vec4(1, 2, 3, 4); in_last = 1'b1;
    next_cycle();
    in_valid = 1'b0; in_last = 1'b0;
    sample_at(3);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("t6_async_lv", laneValid, 0);
    chk("t6_async_data", skewData, 0);
    chk("t6_async_men", macEnable, 0);
    chk("t6_async_td", tileDone, 0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    sample_at(0); chk("t6_inReady", inReady, 1);
    td_seen = 0;
    for (int c = 1; c <= 15; c++) begin
      sample_at(c);
      td_seen += int'(tileDone) + int'(macClear) + int'(laneValid != 0);
    end
    chk("t6_quiet_after_reset", td_seen, 0);

    // Randomised traffic at several load levels, with one mid-run reset.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 1500; n++) begin
        in_valid = ($urandom_range(0, 99) < (r == 0 ? 30 : (r == 1 ? 70 : 100)));
        in_data  = {$urandom, $urandom};
        in_last  = ($urandom_range(0, 7) == 0);
        if (r == 1 && n == 700) begin
          rst_n = 1'b0;
          repeat (2) next_cycle();
          rst_n = 1'b1;
        end
        next_cycle();
      end
    end
    idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream operand feeder for the systolic MAC array.
- Accepts one N-lane operand vector per handshake, buffers vectors in a FIFO, and issues one vector per cycle.
- Skews the issued vector so that lane i reaches its array edge i cycles after lane 0.
- Sequences tile boundaries: flushes the array, pulses tileDone so the downstream drain captures accOutput, then pulses macClear before the next tile starts.

Parameters:
- dataSize, 16, signed operand width per lane.
- lanes, 4, array rows (or columns) fed by this block.
- fifoDepth, 8, input FIFO entries; must be a power of two, at least 2.
- macLatency, 3, cycles from a MAC input edge to its accumulator update.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- inValid  in  1  producer has a vector.
- inReady  out  1  FIFO can accept a vector.
- inData  in  lanes*dataSize  lane k occupies bits [k*dataSize +: dataSize].
- inLast  in  1  vector is the final one of its tile.
- skewData  out  lanes*dataSize  skewed lane operands, to the array leftInput/topInput.
- laneValid  out  lanes  lane k currently carries real data.
- macEnable  out  1  OR of laneValid; drives MAC enable.
- macClear  out  1  one-cycle accumulator clear.
- tileDone  out  1  one-cycle pulse: accumulators are final and valid.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values: FIFO empty, FSM in IDLE. skewData=0, laneValid=0, macEnable=0, macClear=0, tileDone=0. inReady=1 once reset is released.
- Input handshake: accept a vector when inValid && inReady. inReady = !full, with no same-cycle bypass when full. Each FIFO entry stores {inLast, inData}.
- Issue rule: pop one entry per cycle when the FIFO is non-empty and the FSM is in IDLE or STREAM.
- Lane 0 issue register: loaded with the popped vector, or with 0 and valid=0 if nothing is popped. Empty cycles are therefore bubbles: lane data forced to 0, laneValid low.
- Skew: lane i output = lane i of the issue register delayed i further cycles. Lane 0 has no extra delay; lane lanes-1 has lanes-1 extra cycles. laneValid[i] follows the same delay.
- Latency: handshake in cycle t; the vector is popped in cycle t+1 at the earliest; lane i is visible in cycle t+2+i.
- Values pass unchanged, sign intact; no arithmetic is performed on operands.
- FSM states:
  - IDLE: pop when non-empty; go to STREAM. If the popped entry has last=1, go straight to FLUSH.
  - STREAM: pop when non-empty; if empty, issue a bubble and stay. Popping an entry with last=1 goes to FLUSH.
  - FLUSH: no pops. A counter loaded with lanes-1+macLatency decrements each cycle; at 0, go to DONE.
  - DONE: tileDone=1 for one cycle; no pops; go to CLEAR.
  - CLEAR: macClear=1 for one cycle; no pops; go to IDLE.
- macClear and the first vector of the next tile never coincide: the earliest next-tile pop is in IDLE, the cycle after CLEAR.
- Pushes continue in every state; the FIFO keeps filling during FLUSH, DONE and CLEAR.
- A tile of one vector is legal.
- A bubble inside a tile does not end the tile; only inLast does.
- Reset asserted mid-operation: immediate return to reset values. In-flight FIFO contents and skew-pipe data are discarded. No tileDone or macClear pulse is emitted.
- Simultaneous push and pop when not full: both occur, and occupancy is unchanged.

Decomposition:
- Shared package tpu_pkg:
  - feeder_state_t enum {IDLE, STREAM, FLUSH, DONE, CLEAR}.
  - Function computing the flush count (lanes-1+macLatency) and the counter width via $clog2.
- Sub-module skew_delay_line:
  - Parameters dataSize and delay.
  - Shift register of {valid, data}; delay=0 is a wire-through.
  - One instance per lane in a generate loop.
- The FIFO stays inline: circular buffer with read/write pointers and a count.

Test Plan (lanes=4, macLatency=3, fifoDepth=8):
1. Single-vector tile: push lane0..3 = {1,2,3,4} with inLast in cycle 0 -> lane i = i+1 valid in cycle 2+i. FLUSH covers cycles 2..7; tileDone in cycle 8; macClear in cycle 9; IDLE in cycle 10.
2. Back-to-back tiles: tile A = 3 vectors with inLast on the third, tile B queued behind it -> no pop during FLUSH, DONE or CLEAR. Tile B's first pop is in the cycle after macClear, and no B data appears on skewData before then.
3. FIFO full: push 10 vectors continuously, first vector with inLast -> inReady drops after the 9th accept (1 popped + 8 stored). The 10th vector stalls until the pop in IDLE, then is accepted.
4. Bubble: push v0=(5,5,5,5), idle 2 cycles, push v1=(-3,-3,-3,-3) with inLast -> lane 0 shows 5, 0, 0, -3. laneValid[0] pattern is 1,0,0,1; macEnable low only when all lanes are invalid.
5. Extremes: lane data -32768 and 32767 appear bit-exact at the lane outputs with the correct skew.
6. Reset mid-FLUSH: drop reset in cycle 4 of test 1 -> all outputs are 0 asynchronously and no tileDone occurs. After release, inReady=1 and the FIFO is empty.
